// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem_loader byte-stream program loader.
// Holds the loader state encoding, header size and memory address width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int ADR_W     = 64;

    // True while a load is consuming bytes from the source.
    function automatic logic is_loading(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// 8-bit running sum of payload bytes with compare against a reference byte.
// Sum updates one cycle after en; match is combinational; no backpressure.
// Only instantiated by imem_loader when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    input  logic [7:0] cmp_byte,
    output logic       match
);

    logic [7:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum + din;
        end
    end

    assign match = (sum == cmp_byte);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory; busy holds the CPU meanwhile.
// Writes appear one cycle after each payload handshake; done/err one cycle after the last byte.
// s_ready is high only while loading; the source may stall freely via s_valid. Macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SIZE  = 256,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count
);

    state_t state, state_nxt;

    logic [7:0]             len_lo;
    logic [LEN_W-1:0]       len_q;
    logic [8*HDR_BYTES-1:0] hdr_len;
    logic                   hs;
    logic                   start_ok;
    logic                   last_byte;
    logic                   oversize;
    logic                   in_range;

    assign hs        = s_valid && s_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign hdr_len   = {s_data, len_lo};
    assign last_byte = (count == (len_q - LEN_W'(1)));
    assign oversize  = (32'(hdr_len) > 32'(SIZE));
    assign in_range  = (32'(count) < 32'(SIZE));

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CSUM;

    logic csum_match;

    imem_loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .en       (hs && (state == DATA)),
        .din      (s_data),
        .cmp_byte (s_data),
        .match    (csum_match)
    );
`else
    localparam state_t TAIL = DONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = LEN_LO;
            LEN_LO:     if (hs) state_nxt = LEN_HI;
            LEN_HI:     if (hs) state_nxt = (hdr_len == '0) ? TAIL : DATA;
            DATA:       if (hs && last_byte) state_nxt = TAIL;
            CSUM:       if (hs) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = is_loading(state);
        busy    = is_loading(state);
        done    = (state == DONE);
    end

    // Oversize streams are still fully consumed; only the memory write is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo    <= 8'h00;
            len_q     <= '0;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                count <= '0;
                err   <= 1'b0;
            end
            case (state)
                LEN_LO: begin
                    if (hs) len_lo <= s_data;
                end
                LEN_HI: begin
                    if (hs) begin
                        len_q <= LEN_W'(hdr_len);
                        if (oversize) err <= 1'b1;
                    end
                end
                DATA: begin
                    if (hs) begin
                        count <= count + LEN_W'(1);
                        if (in_range) begin
                            mem_we    <= 1'b1;
                            mem_adr   <= ADR_W'(count);
                            mem_wdata <= s_data;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (hs && !csum_match) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
